reg_bank: RTL

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank.sv | 52 +++++
 1 files changed

// File: rtl/reg_bank.sv
// 32 x 32-bit register file: two registered read ports, one write port,
// write-first bypass on same-edge hazards, register 0 hard-wired to zero.
module reg_bank #(
   parameter logic [31:0] SP_INIT = 32'd227
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        RegWrite,
   input  logic [4:0]  ReadReg1,
   input  logic [4:0]  ReadReg2,
   input  logic [4:0]  WriteReg,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData1,
   output logic [31:0] ReadData2
);

   logic [31:0] regs_q [32];
   logic [31:0] rd1_q, rd1_d;
   logic [31:0] rd2_q, rd2_d;

   // Index 0 forces zero first, so a same-cycle write to r0 can never bypass.
   always_comb begin
      rd1_d = '0;
      rd2_d = '0;
      if (ReadReg1 != 5'd0) begin
         if (RegWrite && (WriteReg == ReadReg1)) rd1_d = WriteData;
         else                                    rd1_d = regs_q[ReadReg1];
      end
      if (ReadReg2 != 5'd0) begin
         if (RegWrite && (WriteReg == ReadReg2)) rd2_d = WriteData;
         else                                    rd2_d = regs_q[ReadReg2];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < 32; i++) begin
            regs_q[i[4:0]] <= (i == 32'd29) ? SP_INIT : '0;
         end
         rd1_q <= '0;
         rd2_q <= '0;
      end else begin
         if (RegWrite && (WriteReg != 5'd0)) regs_q[WriteReg] <= WriteData;
         rd1_q <= rd1_d;
         rd2_q <= rd2_d;
      end
   end

   assign ReadData1 = rd1_q;
   assign ReadData2 = rd2_q;

endmodule
